mini_alu_param: RTL and testbench
=================================

# mini_alu_param

Parametrised successor to the single-cycle mini ALU core, adding a stall/handshake keyboard read, conditional branches and a halt state. It fetches from an external instruction ROM through an address/data port and holds the data register file internally. It drives the board LEDs and consumes scan codes from the PS/2 keyboard decoder through a valid/ack handshake. It sits at the top of each lab design, between the instruction ROM, the keyboard decoder and the LED pins.

## Interface
Parameters:
- DATA_W, 16: register and ALU data width.
- ADDR_W, 8: register-address and branch-target field width; register count is 2**ADDR_W.
- IP_W, 16: instruction-pointer width; branch targets are zero-extended to IP_W.
- LED_W, 8: LED output width, with LED_W <= DATA_W.
- KEY_W, 8: scan-code width, with KEY_W <= DATA_W.

Ports:
- Clock  in  1  single system clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- oIAddress  out  IP_W  instruction ROM address; the ROM is combinational.
- iInstruction  in  4+3*ADDR_W  instruction word: {op[3:0], dst, src1, src0}.
- iKeyData  in  KEY_W  scan code from the keyboard decoder.
- iKeyValid  in  1  scan code available; held high until acked.
- oKeyAck  out  1  one-cycle pulse when the scan code is consumed.
- oLed  out  LED_W  registered LED value.
- oStall  out  1  high while KEY waits on iKeyValid.
- oHalted  out  1  high after HLT executes.

## Operation
- Two stages:
  - Fetch presents oIAddress and latches iInstruction into the execute register.
  - Execute reads R[src1] and R[src0] combinationally and writes R[dst] at the clock edge.
- Immediate value is {src1,src0}, zero-extended or truncated to DATA_W.
- Opcodes are defined in the package:
  - NOP 0x0
  - ADD 0x1: R[dst] = R[src1]+R[src0], mod 2**DATA_W.
  - SUB 0x2: R[src1]-R[src0], wraps.
  - SMUL 0x3: signed product, low DATA_W bits written.
  - STO 0x4: R[dst] = immediate.
  - BLE 0x5: branch to dst if R[src1] <= R[src0], unsigned.
  - BEQ 0x6: branch to dst if R[src1] == R[src0].
  - JMP 0x7: unconditional branch to dst.
  - LED 0x8: oLed <= R[src1][LED_W-1:0].
  - KEY 0x9: R[dst] <= zero-extended iKeyData.
  - HLT 0xA: halt.
  - Any other opcode executes as NOP.
- Branch has zero penalty:
  - When taken, oIAddress = target combinationally in the same cycle, and pc <= target+1.
  - The fetched instruction is the target's, so nothing is squashed.
- The execute path is a state machine with states RUN, KEYWAIT and HALT:
  - RUN -> KEYWAIT when KEY executes with iKeyValid=0. No write occurs, pc and the execute register hold, and oStall=1.
  - KEYWAIT -> RUN in the first cycle iKeyValid=1. R[dst] is written, oKeyAck=1 for that cycle, and pc advances.
  - KEY with iKeyValid already high completes in one cycle and never enters KEYWAIT.
  - RUN -> HALT on HLT. pc freezes at the HLT address+1, and no further writes, LED loads or acks occur.
  - HALT is left only by Reset.
- Register file contents are not cleared by Reset. They are undefined at power-up and retained across Reset.
- pc wraps modulo 2**IP_W.

## Timing
- Reset values:
  - pc = 0, oIAddress = 0.
  - Execute register = NOP.
  - oLed = 0, oKeyAck = 0, oStall = 0, oHalted = 0, state = RUN.
- Reset asserted mid-KEYWAIT or in HALT returns to these values on the next edge. No ack is issued in that case.
- Latency:
  - An instruction fetched at cycle t executes at t+1.
  - A result written at the end of t+1 is visible to the instruction executing at t+2, so there is no hazard.
  - oLed updates at the edge ending the LED execute cycle.
- oKeyAck is registered: it is high in the cycle after the consuming edge, for exactly one cycle. The decoder drops iKeyValid on seeing it.
- Back-to-back KEY:
  - The second KEY must not reuse the same scan code.
  - While oKeyAck is high, iKeyValid is ignored. This gives a one-cycle stall minimum.
- oStall and oHalted are decoded from state and are glitch-free registered values.

## Structure
- Package mini_alu_pkg holds:
  - Opcode localparams.
  - State encoding for RUN, KEYWAIT and HALT.
  - Field-slice helper constants for op/dst/src1/src0 as a function of ADDR_W.
- Sub-module mini_alu_regfile(DATA_W, ADDR_W) provides two combinational read ports and one synchronous write port. It has no reset.
- Everything else stays in one module: fetch counter, execute register, FSM, ALU/multiplier, LED register and ack register.

## Test plan
- Reset: hold Reset 3 cycles -> oIAddress=0, oLed=0, oStall=0, oHalted=0, oKeyAck=0.
- Arithmetic to LED: STO R1,5; STO R2,7; ADD R3,R2,R1; LED R3 -> oLed=0x0C one edge after the LED execute cycle. Then SUB R4,R1,R2; LED R4 -> oLed=0xFE.
- SMUL: R1=0xFFFD (-3), R2=4, SMUL R3 -> R3=0xFFF4. Also 0x7FFF*0x0002 -> 0xFFFE (truncation).
- Branch loop: counter from 0 step 1, BLE back while ≤ 9, then LED -> exactly 10 loop passes and no wrong-path write. BEQ not-taken falls through to the next address.
- KEY handshake: iKeyValid=0 for 10 cycles -> oStall=1 and oIAddress constant. Then iKeyData=0x1C with valid -> R[dst]=0x001C, oKeyAck pulses once, and the next KEY stalls at least 1 cycle.
- HLT and reset mid-stall:
  - After HLT, 20 cycles with valid keys -> no acks, oHalted=1, oIAddress frozen.
  - Reset during KEYWAIT -> RUN at address 0 with no ack.

Source files
------------

// File: rtl/mini_alu_pkg.sv
// mini_alu_pkg: opcodes, execute-state encoding and instruction field positions
package mini_alu_pkg;
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_SMUL = 4'h3;
  localparam logic [3:0] OP_STO  = 4'h4;
  localparam logic [3:0] OP_BLE  = 4'h5;
  localparam logic [3:0] OP_BEQ  = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_LED  = 4'h8;
  localparam logic [3:0] OP_KEY  = 4'h9;
  localparam logic [3:0] OP_HLT  = 4'hA;

  typedef enum logic [1:0] {RUN = 2'd0, KEYWAIT = 2'd1, HALT = 2'd2} aluState_e;

  localparam int SRC0_LSB = 0;

  function automatic int instrWidth(int addrW);
    return 4 + 3 * addrW;
  endfunction

  function automatic int opLsb(int addrW);
    return 3 * addrW;
  endfunction

  function automatic int dstLsb(int addrW);
    return 2 * addrW;
  endfunction

  function automatic int src1Lsb(int addrW);
    return addrW;
  endfunction
endpackage

// File: rtl/mini_alu_regfile.sv
// mini_alu_regfile: data registers with two combinational reads and one clocked write
module mini_alu_regfile
  import mini_alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              Clock,
  input  logic              iWrEn,
  input  logic [ADDR_W-1:0] iWrAddr,
  input  logic [DATA_W-1:0] iWrData,
  input  logic [ADDR_W-1:0] iRdAddrA,
  input  logic [ADDR_W-1:0] iRdAddrB,
  output logic [DATA_W-1:0] oRdDataA,
  output logic [DATA_W-1:0] oRdDataB
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  // contents deliberately survive reset
  always_ff @(posedge Clock) begin
    if (iWrEn) mem[iWrAddr] <= iWrData;
  end
  assign oRdDataA = mem[iRdAddrA];
  assign oRdDataB = mem[iRdAddrB];
endmodule

// File: rtl/mini_alu_param.sv
// mini_alu_param: two-stage mini ALU core with keyboard handshake, branches and halt
module mini_alu_param
  import mini_alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int IP_W   = 16,
  parameter int LED_W  = 8,
  parameter int KEY_W  = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  output logic [IP_W-1:0]       oIAddress,
  input  logic [4+3*ADDR_W-1:0] iInstruction,
  input  logic [KEY_W-1:0]      iKeyData,
  input  logic                  iKeyValid,
  output logic                  oKeyAck,
  output logic [LED_W-1:0]      oLed,
  output logic                  oStall,
  output logic                  oHalted
);
  localparam int INSTR_W  = instrWidth(ADDR_W);
  localparam int OP_LSB   = opLsb(ADDR_W);
  localparam int DST_LSB  = dstLsb(ADDR_W);
  localparam int SRC1_LSB = src1Lsb(ADDR_W);

  logic [IP_W-1:0]    pc;
  logic [INSTR_W-1:0] exInstr;
  aluState_e          state, stateNext;
  logic [3:0]         op;
  logic [ADDR_W-1:0]  dst, src1, src0;
  logic [DATA_W-1:0]  rdA, rdB, wrData, imm, keyExt, smulRes;
  logic               wrEn, branch, hold, ledLoad, keyTake, keyReady;

  assign op     = exInstr[OP_LSB +: 4];
  assign dst    = exInstr[DST_LSB +: ADDR_W];
  assign src1   = exInstr[SRC1_LSB +: ADDR_W];
  assign src0   = exInstr[SRC0_LSB +: ADDR_W];
  assign imm    = DATA_W'({src1, src0});
  assign keyExt = DATA_W'(iKeyData);
  assign smulRes = $signed(rdA) * $signed(rdB);
  // a scan code is never taken in the cycle its predecessor is being acked
  assign keyReady = iKeyValid && !oKeyAck;
  // taken branches redirect the fetch in the same cycle, so nothing is squashed
  assign oIAddress = branch ? IP_W'(dst) : pc;

  mini_alu_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) regs (
    .Clock    (Clock),
    .iWrEn    (wrEn && !Reset),
    .iWrAddr  (dst),
    .iWrData  (wrData),
    .iRdAddrA (src1),
    .iRdAddrB (src0),
    .oRdDataA (rdA),
    .oRdDataB (rdB)
  );

  // execute decode: register write, branch, LED load, key handshake and next state
  always_comb begin
    stateNext = state;
    wrEn      = 1'b0;
    wrData    = '0;
    branch    = 1'b0;
    ledLoad   = 1'b0;
    keyTake   = 1'b0;
    hold      = 1'b0;
    case (state)
      RUN: case (op)
        OP_ADD:  begin wrEn = 1'b1; wrData = rdA + rdB; end
        OP_SUB:  begin wrEn = 1'b1; wrData = rdA - rdB; end
        OP_SMUL: begin wrEn = 1'b1; wrData = smulRes; end
        OP_STO:  begin wrEn = 1'b1; wrData = imm; end
        OP_BLE:  branch = rdA <= rdB;
        OP_BEQ:  branch = rdA == rdB;
        OP_JMP:  branch = 1'b1;
        OP_LED:  ledLoad = 1'b1;
        OP_KEY:  begin
          wrEn      = keyReady;
          wrData    = keyExt;
          keyTake   = keyReady;
          hold      = !keyReady;
          stateNext = keyReady ? RUN : KEYWAIT;
        end
        OP_HLT:  begin hold = 1'b1; stateNext = HALT; end
        default: ;
      endcase
      KEYWAIT: begin
        wrEn      = keyReady;
        wrData    = keyExt;
        keyTake   = keyReady;
        hold      = !keyReady;
        stateNext = keyReady ? RUN : KEYWAIT;
      end
      default: hold = 1'b1;
    endcase
  end

  // fetch counter, execute register, FSM state and registered outputs
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc      <= '0;
      exInstr <= '0;
      state   <= RUN;
      oLed    <= '0;
      oKeyAck <= 1'b0;
      oStall  <= 1'b0;
      oHalted <= 1'b0;
    end else begin
      state   <= stateNext;
      oKeyAck <= keyTake;
      oStall  <= stateNext == KEYWAIT;
      oHalted <= stateNext == HALT;
      if (ledLoad) oLed <= rdA[LED_W-1:0];
      if (!hold) begin
        pc      <= oIAddress + IP_W'(1);
        exInstr <= iInstruction;
      end
    end
  end
endmodule

// File: tb/tb_mini_alu_param.sv
// tb_mini_alu_param: directed and random programs checked against an instruction-level model
module tb_mini_alu_param;
  import mini_alu_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] oIAddress;
  logic [27:0] iInstruction;
  logic [7:0]  iKeyData = 8'h00;
  logic        iKeyValid = 1'b0;
  logic        oKeyAck;
  logic [7:0]  oLed;
  logic        oStall, oHalted;

  logic [27:0] rom [256];
  logic [7:0]  keys [64];
  logic [7:0]  ledLog[$];
  logic [7:0]  mLog[$];
  logic [7:0]  prevLed;
  int          vectors = 0, miscompares = 0;
  int          ackCount, keyPtr, keyDelay;
  bit          autoKey;

  mini_alu_param #(.DATA_W(16), .ADDR_W(8), .IP_W(16), .LED_W(8), .KEY_W(8)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .oIAddress    (oIAddress),
    .iInstruction (iInstruction),
    .iKeyData     (iKeyData),
    .iKeyValid    (iKeyValid),
    .oKeyAck      (oKeyAck),
    .oLed         (oLed),
    .oStall       (oStall),
    .oHalted      (oHalted)
  );

  always #5 Clock = ~Clock;
  assign iInstruction = (oIAddress < 16'd256) ? rom[oIAddress[7:0]] : {OP_HLT, 24'h0};

  function automatic logic [27:0] ins(logic [3:0] op, int d, int a, int b);
    return {op, 8'(d), 8'(a), 8'(b)};
  endfunction

  function automatic logic [27:0] sto(int d, int v);
    return {OP_STO, 8'(d), 16'(v)};
  endfunction

  task automatic checkEq(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic checkLog(string tag, input logic [7:0] exp[$]);
    checkEq({tag, "_count"}, ledLog.size(), exp.size());
    for (int i = 0; i < exp.size() && i < ledLog.size(); i++) checkEq(tag, ledLog[i], exp[i]);
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
    if (oKeyAck === 1'b1) ackCount++;
    if (oLed !== prevLed) begin
      ledLog.push_back(oLed);
      prevLed = oLed;
    end
    if (autoKey) begin
      if (iKeyValid && oKeyAck) iKeyValid = 1'b0;
      else if (!iKeyValid) begin
        if (keyDelay > 0) keyDelay--;
        else if (keyPtr < 64) begin
          iKeyData  = keys[keyPtr];
          keyPtr++;
          iKeyValid = 1'b1;
          keyDelay  = $urandom_range(0, 3);
        end
      end
    end
  endtask

  task automatic resetDut();
    Reset     = 1'b1;
    iKeyValid = 1'b0;
    autoKey   = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    Reset    = 1'b0;
    ledLog.delete();
    prevLed  = 8'h00;
    ackCount = 0;
    keyPtr   = 0;
    keyDelay = 0;
  endtask

  task automatic clearRom();
    for (int i = 0; i < 256; i++) rom[i] = ins(OP_HLT, 0, 0, 0);
  endtask

  task automatic runUntilHalt(int maxCyc);
    int n = 0;
    while (oHalted !== 1'b1 && n < maxCyc) begin
      step();
      n++;
    end
    checkEq("halted", oHalted, 1);
  endtask

  // architectural interpreter: one instruction per iteration, pc simply jumps on branches
  task automatic modelRun(output int hltAt, output int used);
    logic [15:0] r [256];
    logic [7:0]  led = 8'h00;
    int          p = 0;
    mLog.delete();
    used  = 0;
    hltAt = -1;
    for (int s = 0; s < 2000 && p < 256; s++) begin
      logic [27:0] w;
      logic [3:0]  op;
      int          d, a, b, prod;
      w  = rom[p];
      op = w[27:24];
      d  = int'(w[23:16]);
      a  = int'(w[15:8]);
      b  = int'(w[7:0]);
      p  = p + 1;
      if (op == OP_HLT) begin
        hltAt = p - 1;
        break;
      end
      case (op)
        OP_ADD:  r[d] = 16'(int'(r[a]) + int'(r[b]));
        OP_SUB:  r[d] = 16'(int'(r[a]) - int'(r[b]));
        OP_SMUL: begin
          prod = int'($signed(r[a])) * int'($signed(r[b]));
          r[d] = prod[15:0];
        end
        OP_STO:  r[d] = w[15:0];
        OP_BLE:  if (r[a] <= r[b]) p = d;
        OP_BEQ:  if (r[a] == r[b]) p = d;
        OP_JMP:  p = d;
        OP_LED:  if (r[a][7:0] != led) begin
          led = r[a][7:0];
          mLog.push_back(led);
        end
        OP_KEY:  begin
          r[d] = {8'h00, keys[used]};
          used++;
        end
        default: ;
      endcase
    end
  endtask

  initial begin
    int hltAt, used, hltAddr, addr, op, d;
    for (int i = 0; i < 64; i++) keys[i] = 8'($urandom);

    // arithmetic, SMUL and BEQ program
    clearRom();
    rom[0]  = sto(1, 16'h0005);
    rom[1]  = sto(2, 16'h0007);
    rom[2]  = ins(OP_ADD, 3, 2, 1);
    rom[3]  = ins(OP_LED, 0, 3, 0);
    rom[4]  = ins(OP_SUB, 4, 1, 2);
    rom[5]  = ins(OP_LED, 0, 4, 0);
    rom[6]  = sto(5, 16'hFFFD);
    rom[7]  = sto(6, 16'h0004);
    rom[8]  = ins(OP_SMUL, 7, 5, 6);
    rom[9]  = sto(8, 16'hFFF4);
    rom[10] = ins(OP_LED, 0, 7, 0);
    rom[11] = ins(OP_BEQ, 14, 7, 8);
    rom[12] = ins(OP_LED, 0, 5, 0);
    rom[14] = ins(OP_LED, 0, 6, 0);
    rom[15] = sto(10, 16'h7FFF);
    rom[16] = sto(11, 16'h0002);
    rom[17] = ins(OP_SMUL, 12, 10, 11);
    rom[18] = sto(13, 16'hFFFE);
    rom[19] = ins(OP_BEQ, 22, 12, 13);
    rom[20] = ins(OP_LED, 0, 10, 0);
    rom[22] = ins(OP_LED, 0, 11, 0);
    resetDut();
    checkEq("rst_addr", oIAddress, 0);
    checkEq("rst_led", oLed, 0);
    checkEq("rst_stall", oStall, 0);
    checkEq("rst_halted", oHalted, 0);
    checkEq("rst_ack", oKeyAck, 0);
    repeat (4) step();
    checkEq("led_not_yet", oLed, 8'h00);
    step();
    checkEq("led_timing", oLed, 8'h0C);
    runUntilHalt(200);
    checkLog("arith", '{8'h0C, 8'hFE, 8'hF4, 8'h04, 8'h02});
    checkEq("arith_halt_addr", oIAddress, 24);

    // counting loop with BLE, then a not-taken BEQ
    clearRom();
    rom[0]  = sto(1, 0);
    rom[1]  = sto(2, 1);
    rom[2]  = sto(3, 9);
    rom[3]  = sto(5, 16'h0010);
    rom[4]  = ins(OP_ADD, 5, 5, 2);
    rom[5]  = ins(OP_ADD, 1, 1, 2);
    rom[6]  = ins(OP_BLE, 4, 1, 3);
    rom[7]  = ins(OP_LED, 0, 5, 0);
    rom[8]  = ins(OP_LED, 0, 1, 0);
    rom[9]  = ins(OP_BEQ, 12, 1, 3);
    rom[10] = ins(OP_LED, 0, 2, 0);
    rom[12] = ins(OP_LED, 0, 3, 0);
    resetDut();
    runUntilHalt(300);
    checkLog("loop", '{8'h1A, 8'h0A, 8'h01});
    checkEq("loop_halt_addr", oIAddress, 12);
    autoKey = 1'b1;
    repeat (20) step();
    checkEq("halt_no_ack", ackCount, 0);
    checkEq("halt_flag", oHalted, 1);
    checkEq("halt_addr_frozen", oIAddress, 12);
    checkEq("halt_led_frozen", oLed, 8'h01);

    // keyboard handshake with back-to-back KEY
    clearRom();
    rom[0] = ins(OP_KEY, 1, 0, 0);
    rom[1] = ins(OP_KEY, 2, 0, 0);
    rom[2] = sto(3, 16'h001C);
    rom[3] = ins(OP_LED, 0, 1, 0);
    rom[4] = ins(OP_LED, 0, 2, 0);
    rom[5] = ins(OP_BEQ, 8, 1, 3);
    rom[8] = sto(4, 16'h0055);
    rom[9] = ins(OP_LED, 0, 4, 0);
    resetDut();
    repeat (10) step();
    checkEq("key_stall", oStall, 1);
    checkEq("key_addr_hold", oIAddress, 1);
    checkEq("key_no_ack_yet", ackCount, 0);
    iKeyData  = 8'h1C;
    iKeyValid = 1'b1;
    step();
    checkEq("key_ack", oKeyAck, 1);
    checkEq("key_stall_clear", oStall, 0);
    step();
    checkEq("key_ack_once", oKeyAck, 0);
    checkEq("key_b2b_stall", oStall, 1);
    iKeyValid = 1'b0;
    repeat (2) step();
    checkEq("key_wait2", oStall, 1);
    iKeyData  = 8'h2A;
    iKeyValid = 1'b1;
    step();
    checkEq("key_ack2", oKeyAck, 1);
    iKeyValid = 1'b0;
    runUntilHalt(100);
    checkLog("key", '{8'h1C, 8'h2A, 8'h55});
    checkEq("key_acks", ackCount, 2);
    checkEq("key_halt_addr", oIAddress, 11);

    // reset while waiting for a key
    clearRom();
    rom[0] = ins(OP_KEY, 1, 0, 0);
    rom[1] = ins(OP_LED, 0, 1, 0);
    resetDut();
    repeat (5) step();
    checkEq("rstw_stall", oStall, 1);
    iKeyData  = 8'h33;
    iKeyValid = 1'b1;
    Reset     = 1'b1;
    step();
    checkEq("rstw_stall_clr", oStall, 0);
    checkEq("rstw_addr", oIAddress, 0);
    checkEq("rstw_ack", oKeyAck, 0);
    Reset     = 1'b0;
    iKeyValid = 1'b0;
    step();
    checkEq("rstw_ack_after", oKeyAck, 0);
    checkEq("rstw_acks", ackCount, 0);

    // random programs with forward branches against the interpreter
    for (int it = 0; it < 6; it++) begin
      clearRom();
      hltAddr = 8 + 40 + 8;
      for (int r = 0; r < 8; r++) rom[r] = sto(r, int'($urandom_range(0, 65535)));
      for (int i = 0; i < 40; i++) begin
        addr = 8 + i;
        op   = $urandom_range(0, 15);
        if (op == int'(OP_HLT)) op = int'(OP_LED);
        d = (op >= 5 && op <= 7) ? $urandom_range(addr + 1, hltAddr) : $urandom_range(0, 7);
        rom[addr] = (op == int'(OP_STO)) ? sto(d, int'($urandom_range(0, 65535)))
                                         : ins(4'(op), d, $urandom_range(0, 7), $urandom_range(0, 7));
      end
      for (int r = 0; r < 8; r++) rom[48 + r] = ins(OP_LED, 0, r, 0);
      modelRun(hltAt, used);
      resetDut();
      autoKey = 1'b1;
      runUntilHalt(3000);
      checkLog("rand_led", mLog);
      checkEq("rand_acks", ackCount, used);
      checkEq("rand_halt_addr", oIAddress, hltAt + 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
